// File: rtl/qmult_sched.sv
// qmult_sched: round-robin scheduler sharing one sign-magnitude Q-format multiplier among NREQ requesters.
// Define QMULT_SCHED_STATS_EN to add saturating grant/stall counters (stat_issue, stat_stall).
module qmult_sched #(
  parameter int Q    = 15,
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  output logic [N-1:0]      res_data,
  output logic [IDW-1:0]    res_id,
  input  logic              res_ready,
  output logic              busy
`ifdef QMULT_SCHED_STATS_EN
  ,
  output logic [31:0]       stat_issue,
  output logic [31:0]       stat_stall
`endif
);

  // Sign-magnitude Q-format product: sign is XOR of signs, magnitude keeps
  // bits [N-2+Q:Q] of the magnitude product (truncation, no saturation).
  function automatic logic [N-1:0] qmult(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-3:0] prod;
    prod = (2*N-2)'(a[N-2:0]) * (2*N-2)'(b[N-2:0]);
    return {a[N-1] ^ b[N-1], (N-1)'(prod >> Q)};
  endfunction

  logic           advance;
  logic           grant_any;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] rr_ptr;

  logic           vld_p1;
  logic [N-1:0]   a_p1;
  logic [N-1:0]   b_p1;
  logic [IDW-1:0] id_p1;

  assign advance = !res_valid || res_ready;
  assign busy    = vld_p1 || res_valid;

  // Wrap-around search starting at rr_ptr; reset gates the grant because
  // res_valid=0 during reset would otherwise leave advance high.
  always_comb begin
    int             idx;
    logic [IDW-1:0] cand;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
    if (rst || !advance) grant_any = 1'b0;
  end

  assign req_ready = grant_any ? (NREQ'(1) << grant_id) : '0;

  // Stage p1: operand register, loaded only on a handshake
  always_ff @(posedge clk) begin
    if (grant_any) begin
      a_p1  <= req_a[grant_id*N +: N];
      b_p1  <= req_b[grant_id*N +: N];
      id_p1 <= grant_id;
    end
  end

  // Stage p2: result register and scheduler control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (advance) begin
        res_valid <= vld_p1;
        if (vld_p1) begin
          res_data <= qmult(a_p1, b_p1);
          res_id   <= id_p1;
        end
        vld_p1 <= grant_any;
      end
      if (grant_any)
        rr_ptr <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
    end
  end

`ifdef QMULT_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issue <= '0;
      stat_stall <= '0;
    end else begin
      if (grant_any && stat_issue != 32'hFFFF_FFFF)
        stat_issue <= stat_issue + 32'd1;
      if (res_valid && !res_ready && stat_stall != 32'hFFFF_FFFF)
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qmult_sched.sv
// Directed bench for qmult_sched (NREQ=4, Q=15, N=32); stat ports checked when QMULT_SCHED_STATS_EN is defined.
module tb_qmult_sched;
  localparam int Q = 15, N = 32, NREQ = 4, IDW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic [N-1:0]      res_data;
  logic [IDW-1:0]    res_id;
  logic              res_ready;
  logic              busy;
`ifdef QMULT_SCHED_STATS_EN
  logic [31:0]       stat_issue, stat_stall;
`endif

  int n_cmp = 0;
  int n_err = 0;

  qmult_sched #(.Q(Q), .N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
    .res_ready(res_ready), .busy(busy)
`ifdef QMULT_SCHED_STATS_EN
    , .stat_issue(stat_issue), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 4'b1111;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b1;
    tick(); tick();
    #1;
    check("rst_ready_gated", req_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_id", res_id, 0);
    check("rst_busy", busy, 0);
    req_valid = '0;
    tick();
    rst = 1'b0;

    // 1: single request, 2.0 * 3.0 = 6.0
    set_ops(0, 32'h0001_0000, 32'h0001_8000);
    req_valid = 4'b0001;
    #1 check("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    check("t1_s1_busy", busy, 1);
    check("t1_not_yet", res_valid, 0);
    tick();
    check("t1_valid", res_valid, 1);
    check("t1_data", res_data, 32'h0003_0000);
    check("t1_id", res_id, 0);
    tick();
    check("t1_drain_valid", res_valid, 0);
    check("t1_drain_busy", busy, 0);

    // 4: fairness skip, rr_ptr=1 after the grant to 0
    set_ops(3, 32'h0002_0000, 32'h0000_8000);
    set_ops(0, 32'h8001_0000, 32'h0001_8000);
    req_valid = 4'b1001;
    #1 check("t4_first_grant", req_ready, 4'b1000);
    tick();
    #1 check("t4_second_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    check("t4_id3", res_id, 3);
    check("t4_data3", res_data, 32'h0002_0000);
    tick();
    check("t4_id0", res_id, 0);
    check("t4_data0_neg", res_data, 32'h8003_0000);
    tick();
    check("t4_drain", res_valid, 0);

    // 5: reset with both stages full, then first grant to requester 0
    set_ops(0, 32'h0000_8000, 32'h0000_8000);
    req_valid = 4'b0001;
    tick(); tick();
    check("t5_full_valid", res_valid, 1);
    check("t5_full_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", res_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_ready", req_ready, 0);
    tick();
    for (int i = 0; i < NREQ; i++) set_ops(i, N'((i + 1) << 15), 32'h0001_0000);
    req_valid = 4'b1111;
    rst = 1'b0;

    // 2: all four requesting; grants 0,1,2,3,0 and products (i+1)*2.0
    for (int k = 0; k < 5; k++) begin
      #1 check($sformatf("t2_grant%0d", k), req_ready, 4'b0001 << (k % 4));
      if (k >= 2) begin
        check($sformatf("t2_id%0d", k), res_id, (k - 2) % 4);
        check($sformatf("t2_data%0d", k), res_data, ((k - 2) % 4 + 1) << 16);
      end
      tick();
    end
    req_valid = '0;
    check("t2_id3", res_id, 3);
    check("t2_data3", res_data, 32'h0004_0000);
    tick();
    check("t2_id_wrap", res_id, 0);
    check("t2_data_wrap", res_data, 32'h0001_0000);
    tick();
    check("t2_drain", busy, 0);

    // 3: backpressure on a requester-2 stream
    set_ops(2, 32'h0000_8000, 32'h0002_8000);
    req_valid = 4'b0100;
    #1 check("t3_grant_a", req_ready, 4'b0100);
    tick();
    set_ops(2, 32'h0001_0000, 32'h0002_8000);
    tick();
    set_ops(2, 32'h0001_8000, 32'h0002_8000);
    res_ready = 1'b0;
    check("t3_first", res_data, 32'h0002_8000);
    #1 check("t3_stall_ready0", req_ready, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("t3_hold_valid%0d", k), res_valid, 1);
      check($sformatf("t3_hold_data%0d", k), res_data, 32'h0002_8000);
      check($sformatf("t3_hold_ready%0d", k), req_ready, 0);
    end
    tick();
    res_ready = 1'b1;
    check("t3_hold_last", res_data, 32'h0002_8000);
`ifdef QMULT_SCHED_STATS_EN
    check("t3_stat_stall", stat_stall, 3);
    check("t3_stat_issue", stat_issue, 7);
`endif
    #1 check("t3_resume_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    check("t3_held_next", res_data, 32'h0005_0000);
    check("t3_held_id", res_id, 2);
    tick();
    check("t3_third", res_data, 32'h0007_8000);
    tick();
    check("t3_no_dup", res_valid, 0);

    // 6: requester 1 withdraws while stalled
    set_ops(0, 32'h0000_8000, 32'h0000_8000);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    res_ready = 1'b0;
    req_valid = 4'b0010;
    set_ops(1, 32'h0001_0000, 32'h0001_0000);
    #1 check("t6_no_grant", req_ready, 0);
    tick();
    req_valid = '0;
    check("t6_hold_id", res_id, 0);
    check("t6_hold_data", res_data, 32'h0000_8000);
    res_ready = 1'b1;
    tick();
    check("t6_empty_valid", res_valid, 0);
    check("t6_empty_busy", busy, 0);
    tick();
    check("t6_no_late", res_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
